// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the CPU sequencer: datapath widths, FSM state encoding,
// one-hot state bus values and opcode constants.
package cpu_sequencer_pkg;

  localparam int PC_W = 8;
  localparam int OP_W = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam logic [2:0] ST_OH_NONE  = 3'b000;
  localparam logic [2:0] ST_OH_FETCH = 3'b001;
  localparam logic [2:0] ST_OH_EXEC1 = 3'b010;
  localparam logic [2:0] ST_OH_EXEC2 = 3'b100;

  localparam logic [OP_W-1:0] OP_STA = 5'b00001;
  localparam logic [OP_W-1:0] OP_STP = 5'b00010;
  localparam logic [OP_W-1:0] OP_JMP = 5'b00100;
  localparam logic [OP_W-1:0] OP_LDA = 5'b00101;
  localparam logic [OP_W-1:0] OP_JMS = 5'b00110;
  localparam logic [OP_W-1:0] OP_BBL = 5'b00111;

  // IDLE and HALT both present an all-zero state bus.
  function automatic logic [2:0] state_onehot(input state_e s);
    case (s)
      S_FETCH: return ST_OH_FETCH;
      S_EXEC1: return ST_OH_EXEC1;
      S_EXEC2: return ST_OH_EXEC2;
      default: return ST_OH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_ret_stack.sv
// Return-address stack with a combinational top and sticky overflow/underflow
// flags. A simultaneous push and pop performs only the pop.
module ret_stack #(
  parameter int PC_W        = cpu_sequencer_pkg::PC_W,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty,
  output logic            ovf,
  output logic            unf
);

  localparam int AW   = $clog2(STACK_DEPTH);
  localparam int SP_W = AW + 1;

  logic [PC_W-1:0] mem_q [STACK_DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_m1;
  logic [AW-1:0]   top_idx;
  logic [AW-1:0]   wr_idx;
  logic            ovf_q;
  logic            unf_q;

  assign sp_m1   = sp_q - 1'b1;
  assign top_idx = sp_m1[AW-1:0];
  assign wr_idx  = sp_q[AW-1:0];
  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SP_W'(STACK_DEPTH));

  // An empty stack reads as zero so a return from nothing lands at address 0.
  assign top = empty ? '0 : mem_q[top_idx];
  assign ovf = ovf_q;
  assign unf = unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (push && pop) begin
      if (!empty) begin
        sp_q <= sp_m1;
      end
    end else if (push) begin
      if (full) begin
        ovf_q <= 1'b1;
      end else begin
        mem_q[wr_idx] <= din;
        sp_q          <= sp_q + 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        unf_q <= 1'b1;
      end else begin
        sp_q <= sp_m1;
      end
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: FETCH/EXEC1/EXEC2 control FSM, program counter,
// instruction latch and a return-address stack driven by decoder strobes.
module cpu_sequencer #(
  parameter int PC_W        = cpu_sequencer_pkg::PC_W,
  parameter int OP_W        = cpu_sequencer_pkg::OP_W,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [OP_W+PC_W-1:0] imem_data,
  input  logic                 e,
  input  logic                 pc_load,
  input  logic                 pc_inc,
  input  logic                 stack_mux,
  input  logic                 push,
  input  logic                 pop,
  output logic [2:0]           state,
  output logic [OP_W-1:0]      inst,
  output logic [PC_W-1:0]      operand,
  output logic [PC_W-1:0]      pc,
  output logic                 halted,
  output logic                 stk_ovf,
  output logic                 stk_unf
);

  import cpu_sequencer_pkg::*;

  state_e          state_q, state_d;
  logic [2:0]      state_oh_q;
  logic            halted_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [OP_W-1:0] inst_q;
  logic [PC_W-1:0] operand_q;

  logic            exec_active;
  logic            push_en;
  logic            pop_en;
  logic [PC_W-1:0] stk_top;
  logic [PC_W-1:0] target;
  logic            stk_full_unused;
  logic            stk_empty_unused;

  // Decoder strobes only take effect while an instruction is in flight.
  assign exec_active = (state_q == S_FETCH) || (state_q == S_EXEC1) || (state_q == S_EXEC2);
  assign push_en     = exec_active && push;
  assign pop_en      = exec_active && pop;
  assign target      = stack_mux ? stk_top : operand_q;

  ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_en),
    .pop   (pop_en),
    .din   (pc_q),
    .top   (stk_top),
    .full  (stk_full_unused),
    .empty (stk_empty_unused),
    .ovf   (stk_ovf),
    .unf   (stk_unf)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC1;
      S_EXEC1: begin
        if (inst_q == OP_STP) begin
          state_d = S_HALT;
        end else if (e) begin
          state_d = S_EXEC2;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC2: state_d = S_FETCH;
      S_HALT:  if (run) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // A load wins over an increment; the increment wraps silently.
  always_comb begin
    pc_d = pc_q;
    if (exec_active) begin
      if (pc_load) begin
        pc_d = target;
      end else if (pc_inc) begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      state_oh_q <= ST_OH_NONE;
      halted_q   <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
      operand_q  <= '0;
    end else begin
      state_q    <= state_d;
      state_oh_q <= state_onehot(state_d);
      halted_q   <= (state_d == S_HALT);
      pc_q       <= pc_d;
      if (state_q == S_FETCH) begin
        inst_q    <= imem_data[OP_W+PC_W-1:PC_W];
        operand_q <= imem_data[PC_W-1:0];
      end
    end
  end

  assign state   = state_oh_q;
  assign halted  = halted_q;
  assign pc      = pc_q;
  assign inst    = inst_q;
  assign operand = operand_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Vector-table and scoreboard bench for cpu_sequencer: fetch/exec sequencing,
// jumps, call/return, stack limits, PC wrap, halt/resume and mid-instruction reset.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int PW = 8;
  localparam int OW = 5;

  localparam logic [2:0] SZ = 3'b000;
  localparam logic [2:0] SF = 3'b001;
  localparam logic [2:0] S1 = 3'b010;
  localparam logic [2:0] S2 = 3'b100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run, e, pc_load, pc_inc, stack_mux, push, pop;
  logic [OW+PW-1:0] imem_data;
  logic [2:0]    state;
  logic [OW-1:0] inst;
  logic [PW-1:0] operand;
  logic [PW-1:0] pc;
  logic          halted, stk_ovf, stk_unf;

  typedef struct packed {
    logic [2:0]    st;
    logic [PW-1:0] pcv;
    logic [OW-1:0] ins;
    logic [PW-1:0] opr;
    logic          h;
    logic          o;
    logic          u;
  } obs_t;

  typedef struct {
    logic [6:0]    ctl;   // {run, e, pc_load, pc_inc, stack_mux, push, pop}
    logic [OW-1:0] op;
    logic [PW-1:0] opnd;
    obs_t          exp;
  } vec_t;

  vec_t vecs[$];
  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  cpu_sequencer #(.PC_W(PW), .OP_W(OW), .STACK_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .imem_data (imem_data),
    .e         (e),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .stack_mux (stack_mux),
    .push      (push),
    .pop       (pop),
    .state     (state),
    .inst      (inst),
    .operand   (operand),
    .pc        (pc),
    .halted    (halted),
    .stk_ovf   (stk_ovf),
    .stk_unf   (stk_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t ob(input logic [2:0] st, input logic [PW-1:0] pcv,
                              input logic [OW-1:0] ins, input logic [PW-1:0] opr,
                              input logic [2:0] f);
    obs_t o;
    o = {st, pcv, ins, opr, f};
    return o;
  endfunction

  function automatic vec_t mk(input logic [6:0] c, input logic [OW-1:0] op,
                              input logic [PW-1:0] opnd, input logic [2:0] st,
                              input logic [PW-1:0] pcv, input logic [OW-1:0] ins,
                              input logic [PW-1:0] opr, input logic [2:0] f);
    vec_t v;
    v.ctl  = c;
    v.op   = op;
    v.opnd = opnd;
    v.exp  = ob(st, pcv, ins, opr, f);
    return v;
  endfunction

  task automatic drive(input logic [6:0] c, input logic [OW-1:0] op, input logic [PW-1:0] opnd);
    {run, e, pc_load, pc_inc, stack_mux, push, pop} = c;
    imem_data = {op, opnd};
  endtask

  task automatic check(input string name);
    obs_t act, exp;
    act = {state, pc, inst, operand, halted, stk_ovf, stk_unf};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    exp = exp_q.pop_front();
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got state=%b pc=%h inst=%h operand=%h halted=%b ovf=%b unf=%b; want state=%b pc=%h inst=%h operand=%h halted=%b ovf=%b unf=%b",
               name, act.st, act.pcv, act.ins, act.opr, act.h, act.o, act.u,
               exp.st, exp.pcv, exp.ins, exp.opr, exp.h, exp.o, exp.u);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    drive(v.ctl, v.op, v.opnd);
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    // ctl bits: run e ld inc smux push pop
    vecs.push_back(mk(7'b0001010, OP_LDA, 8'h00, SZ, 8'h00, 5'h00,  8'h00, 3'b000)); // IDLE ignores strobes
    vecs.push_back(mk(7'b1000000, OP_LDA, 8'h00, SF, 8'h00, 5'h00,  8'h00, 3'b000));
    vecs.push_back(mk(7'b0101000, OP_LDA, 8'h10, S1, 8'h01, OP_LDA, 8'h10, 3'b000));
    vecs.push_back(mk(7'b0100000, OP_LDA, 8'h10, S2, 8'h01, OP_LDA, 8'h10, 3'b000));
    vecs.push_back(mk(7'b0000000, OP_LDA, 8'h10, SF, 8'h01, OP_LDA, 8'h10, 3'b000));
    vecs.push_back(mk(7'b1001000, OP_JMP, 8'h05, S1, 8'h02, OP_JMP, 8'h05, 3'b000)); // run ignored
    vecs.push_back(mk(7'b0010000, OP_JMP, 8'h05, SF, 8'h05, OP_JMP, 8'h05, 3'b000));
    vecs.push_back(mk(7'b0001000, OP_JMP, 8'h40, S1, 8'h06, OP_JMP, 8'h40, 3'b000));
    vecs.push_back(mk(7'b0011000, OP_JMP, 8'h40, SF, 8'h40, OP_JMP, 8'h40, 3'b000)); // load beats inc
    vecs.push_back(mk(7'b0001000, OP_JMP, 8'h20, S1, 8'h41, OP_JMP, 8'h20, 3'b000));
    vecs.push_back(mk(7'b0010000, OP_JMP, 8'h20, SF, 8'h20, OP_JMP, 8'h20, 3'b000));
    vecs.push_back(mk(7'b0001000, OP_JMS, 8'h80, S1, 8'h21, OP_JMS, 8'h80, 3'b000));
    vecs.push_back(mk(7'b0010010, OP_JMS, 8'h80, SF, 8'h80, OP_JMS, 8'h80, 3'b000)); // push 0x21
    vecs.push_back(mk(7'b0001000, OP_BBL, 8'h00, S1, 8'h81, OP_BBL, 8'h00, 3'b000));
    vecs.push_back(mk(7'b0010101, OP_BBL, 8'h00, SF, 8'h21, OP_BBL, 8'h00, 3'b000)); // return
    vecs.push_back(mk(7'b0010100, OP_JMP, 8'h00, S1, 8'h00, OP_JMP, 8'h00, 3'b000)); // empty top = 0
    vecs.push_back(mk(7'b0101010, OP_JMP, 8'h00, S2, 8'h01, OP_JMP, 8'h00, 3'b000)); // push 0
    vecs.push_back(mk(7'b0001010, OP_JMP, 8'h00, SF, 8'h02, OP_JMP, 8'h00, 3'b000)); // push 1
    vecs.push_back(mk(7'b0001010, OP_LDA, 8'h33, S1, 8'h03, OP_LDA, 8'h33, 3'b000)); // push 2
    vecs.push_back(mk(7'b0001010, OP_LDA, 8'h33, SF, 8'h04, OP_LDA, 8'h33, 3'b000)); // push 3
    vecs.push_back(mk(7'b0001010, OP_LDA, 8'h44, S1, 8'h05, OP_LDA, 8'h44, 3'b010)); // fifth push
    vecs.push_back(mk(7'b0010100, OP_LDA, 8'h44, SF, 8'h03, OP_LDA, 8'h44, 3'b010)); // top = 3
    vecs.push_back(mk(7'b0001011, OP_LDA, 8'h55, S1, 8'h04, OP_LDA, 8'h55, 3'b010)); // push+pop
    vecs.push_back(mk(7'b0110101, OP_LDA, 8'h55, S2, 8'h02, OP_LDA, 8'h55, 3'b010)); // pre-pop top
    vecs.push_back(mk(7'b0000001, OP_LDA, 8'h55, SF, 8'h02, OP_LDA, 8'h55, 3'b010));
    vecs.push_back(mk(7'b0001001, OP_LDA, 8'h66, S1, 8'h03, OP_LDA, 8'h66, 3'b010));
    vecs.push_back(mk(7'b0010101, OP_LDA, 8'h66, SF, 8'h00, OP_LDA, 8'h66, 3'b011)); // underflow
    vecs.push_back(mk(7'b0001000, OP_JMP, 8'hFF, S1, 8'h01, OP_JMP, 8'hFF, 3'b011));
    vecs.push_back(mk(7'b0010000, OP_JMP, 8'hFF, SF, 8'hFF, OP_JMP, 8'hFF, 3'b011));
    vecs.push_back(mk(7'b0001000, OP_STP, 8'h00, S1, 8'h00, OP_STP, 8'h00, 3'b011)); // wrap
    vecs.push_back(mk(7'b0101000, OP_STP, 8'h00, SZ, 8'h01, OP_STP, 8'h00, 3'b111)); // halt
    vecs.push_back(mk(7'b0011111, OP_JMP, 8'h99, SZ, 8'h01, OP_STP, 8'h00, 3'b111)); // HALT ignores
    vecs.push_back(mk(7'b1000000, OP_STP, 8'h00, SF, 8'h01, OP_STP, 8'h00, 3'b011)); // resume
    vecs.push_back(mk(7'b1001000, OP_LDA, 8'h12, S1, 8'h02, OP_LDA, 8'h12, 3'b011));

    drive(7'b0000000, OP_LDA, 8'h00);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(ob(SZ, 8'h00, 5'h00, 8'h00, 3'b000));
    check("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-EXEC1 with a pending load must clear everything at once.
    @(negedge clk);
    drive(7'b0011000, OP_JMP, 8'h77);
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(ob(SZ, 8'h00, 5'h00, 8'h00, 3'b000));
    check("rst_async");
    @(posedge clk);
    #1;
    exp_q.push_back(ob(SZ, 8'h00, 5'h00, 8'h00, 3'b000));
    check("rst_hold");

    @(negedge clk);
    rst_n = 1'b1;
    drive(7'b0011010, OP_JMP, 8'h77);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ob(SZ, 8'h00, 5'h00, 8'h00, 3'b000));
      @(posedge clk);
      #1;
      check($sformatf("idle_after_rst%0d", i));
    end

    @(negedge clk);
    drive(7'b1000000, OP_JMP, 8'h77);
    exp_q.push_back(ob(SF, 8'h00, 5'h00, 8'h00, 3'b000));
    @(posedge clk);
    #1;
    check("run_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
